// File: rtl/matmul_systolic_drain.sv
// matmul_systolic_drain: snapshots the M x N accumulator bank when the array
// reports completion, pulses o_clear back to the array, then streams the
// results row-major, one element per beat, over a valid/ready handshake.
// Optional feature macro: MATMUL_DRAIN_SAT_EN. When defined, each element
// saturates to the signed DATA_WIDTH range; otherwise it keeps the low
// DATA_WIDTH bits.
module matmul_systolic_drain #(
  parameter int DATA_WIDTH = 24,
  parameter int ACC_WIDTH  = 52,
  parameter int M          = 4,
  parameter int N          = 4,
  localparam int RW = (M > 1) ? $clog2(M) : 1,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_done,
  input  logic [ACC_WIDTH*M*N-1:0]    iv_acc,
  output logic                        o_clear,
  output logic                        o_busy,
  output logic [DATA_WIDTH-1:0]       ov_data,
  output logic [RW-1:0]               ov_row,
  output logic [CW-1:0]               ov_col,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_last,
  output logic                        o_overrun
);

  localparam int E  = M * N;
  localparam int IW = (E > 1) ? $clog2(E) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                       state;
  logic [E-1:0][DATA_WIDTH-1:0] conv_acc;
  logic [E-1:0][DATA_WIDTH-1:0] snap;
  logic [IW-1:0]                idx;
  logic [IW-1:0]                nidx;
  logic [RW-1:0]                row;
  logic [CW-1:0]                col;
  logic [DATA_WIDTH-1:0]        data_q;
  logic                         valid_q, busy_q, clear_q, last_q, ovr_q;
  logic                         at_end, capture;

  // Element conversion happens on the way into the snapshot, so the drain
  // path only muxes already-narrowed values.
  for (genvar g = 0; g < E; g++) begin : g_conv
`ifdef MATMUL_DRAIN_SAT_EN
    // Bits from the output sign bit upward must all agree, otherwise the
    // value does not fit and is clamped toward its sign.
    logic [ACC_WIDTH-DATA_WIDTH:0] hi;
    assign hi = iv_acc[g*ACC_WIDTH+DATA_WIDTH-1 +: ACC_WIDTH-DATA_WIDTH+1];
    assign conv_acc[g] = (&hi || ~|hi) ? iv_acc[g*ACC_WIDTH +: DATA_WIDTH]
                       : {hi[ACC_WIDTH-DATA_WIDTH], {(DATA_WIDTH-1){~hi[ACC_WIDTH-DATA_WIDTH]}}};
`else
    logic unused_hi;
    assign conv_acc[g] = iv_acc[g*ACC_WIDTH +: DATA_WIDTH];
    assign unused_hi   = ^iv_acc[g*ACC_WIDTH+DATA_WIDTH +: ACC_WIDTH-DATA_WIDTH];
`endif
  end

  assign at_end  = (idx == IW'(E - 1));
  assign nidx    = idx + 1'b1;
  // A new frame is taken when idle, or on the final transfer (back-to-back).
  assign capture = i_en && i_done && ((state == IDLE) || (i_ready && at_end));

  // Drain FSM: capture, walk the snapshot row-major, track overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      row     <= '0;
      col     <= '0;
      idx     <= '0;
    end else if (i_en) begin
      clear_q <= 1'b0;
      if (state == DRAIN && i_done && !(i_ready && at_end))
        ovr_q <= 1'b1;
      if (capture) begin
        state   <= DRAIN;
        snap    <= conv_acc;
        data_q  <= conv_acc[0];
        row     <= '0;
        col     <= '0;
        idx     <= '0;
        last_q  <= (E == 1);
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        clear_q <= 1'b1;
      end else if (state == DRAIN && i_ready) begin
        if (at_end) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          idx    <= nidx;
          data_q <= snap[nidx];
          last_q <= (nidx == IW'(E - 1));
          if (col == CW'(N - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  // Disable masks the handshake and clear strobes without losing state.
  assign o_valid   = valid_q & i_en;
  assign o_clear   = clear_q & i_en;
  assign o_busy    = busy_q;
  assign ov_data   = data_q;
  assign ov_row    = row;
  assign ov_col    = col;
  assign o_last    = last_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_matmul_systolic_drain.sv
// tb_matmul_systolic_drain: random and directed frames; a scoreboard queue of
// expected beats is filled when a frame is accepted and drained by a monitor
// that watches the handshake on the falling edge.
module tb_matmul_systolic_drain;
  localparam int DW = 24;
  localparam int AW = 52;
  localparam int MM = 4;
  localparam int NN = 4;
  localparam int E  = MM * NN;

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
    bit            last;
  } beat_t;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1, i_en = 1'b0, i_done = 1'b0, i_ready = 1'b0;
  logic [AW*E-1:0]    iv_acc = '0;
  logic               o_clear, o_busy, o_valid, o_last, o_overrun;
  logic [DW-1:0]      ov_data;
  logic [1:0]         ov_row, ov_col;

  beat_t  q[$];
  beat_t  pend[$];
  bit     ovr_pend = 0, exp_ovr = 0, clr_exp = 0;
  longint acc[E];
  int     checks = 0, errors = 0;

  matmul_systolic_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .M(MM), .N(NN)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_done(i_done), .iv_acc(iv_acc),
    .o_clear(o_clear), .o_busy(o_busy), .ov_data(ov_data), .ov_row(ov_row),
    .ov_col(ov_col), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_conv(input longint a);
`ifdef MATMUL_DRAIN_SAT_EN
    if (a > 64'sd8388607)  return 24'h7FFFFF;
    if (a < -64'sd8388608) return 24'h800000;
`endif
    return a[DW-1:0];
  endfunction

  function automatic longint rand_acc();
    longint x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return x >>> 40;
      1: return x >>> (12 + $urandom_range(0, 40));
      2: return 64'sd8388607 + longint'($urandom_range(0, 2)) - 1;
      default: return -64'sd8388608 + longint'($urandom_range(0, 2)) - 1;
    endcase
  endfunction

  // Apply inputs for the current cycle and predict the effect of i_done.
  task automatic drive(input bit en, input bit rdy, input bit dn, input bit rs);
    i_en = en; i_ready = rdy; i_done = dn; i_rst = rs;
    for (int i = 0; i < E; i++) iv_acc[i*AW +: AW] = acc[i][AW-1:0];
    if (dn && en && !rs) begin
      if (q.size() == 0 || (q.size() == 1 && rdy)) begin
        for (int i = 0; i < E; i++)
          pend.push_back('{d: ref_conv(acc[i]), r: i / NN, c: i % NN, last: (i == E - 1)});
      end else begin
        ovr_pend = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input bit en, input bit rdy, input bit dn, input bit rs);
    tick();
    drive(en, rdy, dn, rs);
  endtask

  task automatic wait_q(input int n);
    for (int k = 0; k < 300 && q.size() != n; k++) step(i_en, i_ready, 1'b0, 1'b0);
    if (q.size() != n) chk("wait_timeout", q.size(), n);
  endtask

  task automatic chk_reset();
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_clear", o_clear, 0);
    chk("rst_last", o_last, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_data", ov_data, 0);
    chk("rst_row", ov_row, 0);
    chk("rst_col", ov_col, 0);
  endtask

  // Monitor: compare outputs against the scoreboard head, pop on transfer.
  always @(negedge clk) begin
    if (i_rst) begin
      q.delete(); pend.delete();
      exp_ovr = 0; ovr_pend = 0; clr_exp = 0;
    end else begin
      chk("busy", o_busy, q.size() > 0);
      chk("valid", o_valid, (q.size() > 0) && i_en);
      chk("clear", o_clear, clr_exp && i_en);
      chk("overrun", o_overrun, exp_ovr);
      if (o_valid && q.size() > 0) begin
        chk("data", ov_data, q[0].d);
        chk("row", ov_row, q[0].r);
        chk("col", ov_col, q[0].c);
        chk("last", o_last, q[0].last);
      end
      if (o_valid && i_ready && i_en && q.size() > 0) void'(q.pop_front());
      if (i_en) clr_exp = 0;
      if (pend.size() > 0) begin
        foreach (pend[i]) q.push_back(pend[i]);
        pend.delete();
        clr_exp = 1;
      end
      exp_ovr = exp_ovr | ovr_pend;
      ovr_pend = 0;
    end
  end

  initial begin
    for (int i = 0; i < E; i++) acc[i] = 0;
    drive(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    chk_reset();
    step(1, 1, 0, 0);

    // Single frame, acc = r*4+c, sink always ready.
    for (int i = 0; i < E; i++) acc[i] = i;
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    wait_q(0);
    repeat (3) step(1, 1, 0, 0);

    // Backpressure with a 1,0,0,1 ready pattern.
    for (int i = 0; i < E; i++) acc[i] = rand_acc();
    step(1, 1, 1, 0);
    for (int k = 0; k < 200 && (q.size() > 0 || pend.size() > 0 || k < 2); k++)
      step(1, (k % 4 == 0) || (k % 4 == 3), 0, 0);
    chk("bp_drained", q.size(), 0);
    step(1, 1, 0, 0);

    // Back-to-back: new i_done on the final transfer.
    for (int i = 0; i < E; i++) acc[i] = rand_acc();
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    wait_q(1);
    for (int i = 0; i < E; i++) acc[i] = 100 + i;
    drive(1, 1, 1, 0);
    step(1, 1, 0, 0);
    wait_q(0);
    chk("b2b_no_overrun", o_overrun, 0);
    step(1, 1, 0, 0);

    // Saturation / wrap boundary values.
    for (int i = 0; i < E; i++) acc[i] = rand_acc();
    acc[0] = longint'(1) << 30;
    acc[1] = -(longint'(1) << 30);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    wait_q(0);
    step(1, 1, 0, 0);

    // Enable low for 3 cycles mid-frame, then reset at beat 7.
    for (int i = 0; i < E; i++) acc[i] = rand_acc();
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    wait_q(13);
    drive(0, 1, 0, 0);
    tick(); tick();
    step(1, 1, 0, 0);
    wait_q(9);
    drive(1, 1, 0, 1);
    step(1, 0, 0, 0);
    chk_reset();
    for (int i = 0; i < E; i++) acc[i] = rand_acc();
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    wait_q(0);
    step(1, 1, 0, 0);

    // Overrun: i_done while beat 5 is presented is dropped.
    for (int i = 0; i < E; i++) acc[i] = rand_acc();
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    wait_q(11);
    for (int i = 0; i < E; i++) acc[i] = rand_acc();
    drive(1, 1, 1, 0);
    step(1, 1, 0, 0);
    wait_q(0);
    step(1, 1, 0, 0);
    chk("overrun_sticky", o_overrun, 1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < E; i++) acc[i] = rand_acc();
      step($urandom % 8 != 0, $urandom % 3 != 0, $urandom % 16 == 0, 0);
    end
    step(1, 1, 0, 0);
    wait_q(0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("final_empty", q.size() + pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
